// File: rtl/regfile_scoreboard.sv
// Issue-side hazard scoreboard for the 32-entry register file: RAW/WAW/cap stalls plus a drain sequencer.
// Optional stall statistics counters are enabled with `define REGFILE_SB_STATS_EN.
module regfile_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 5
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             issue_valid_ID_i,
  input  logic             issue_we_ID_i,
  input  logic [4:0]       issue_rd_ID_i,
  input  logic             re1_ID_i,
  input  logic [4:0]       raddr1_ID_i,
  input  logic             re2_ID_i,
  input  logic [4:0]       raddr2_ID_i,
  input  logic             we_WB_i,
  input  logic [4:0]       waddr_WB_i,
  input  logic             drain_req_ID_i,
  output logic             stall_ID_o,
  output logic             drain_done_ID_o,
  output logic [31:0]      busy_CPU_o,
  output logic [CNT_W-1:0] outstanding_CPU_o
`ifdef REGFILE_SB_STATS_EN
  ,
  output logic [31:0]      stall_cnt_CPU_o,
  output logic [31:0]      raw_cnt_CPU_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  drain_state_t     state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;

  logic raw1, raw2, waw, cap, hazard;
  logic fire, set_en, clr_en;

  function automatic logic clr_hit(input logic we, input logic [4:0] wa, input logic [4:0] r);
    return we && (wa == r) && (r != 5'd0);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic inc);
    if (inc && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  // Hazard detection; a same-cycle WB match is forwarded by the register file.
  always_comb begin
    raw1   = re1_ID_i && busy_q[raddr1_ID_i] && !clr_hit(we_WB_i, waddr_WB_i, raddr1_ID_i);
    raw2   = re2_ID_i && busy_q[raddr2_ID_i] && !clr_hit(we_WB_i, waddr_WB_i, raddr2_ID_i);
    waw    = issue_we_ID_i && busy_q[issue_rd_ID_i] && !clr_hit(we_WB_i, waddr_WB_i, issue_rd_ID_i);
    // CAP ignores a same-cycle clear on purpose (conservative).
    cap    = issue_we_ID_i && (issue_rd_ID_i != 5'd0) &&
             (outstanding_q >= CNT_W'(MAX_OUTSTANDING));
    hazard = raw1 || raw2 || waw || cap;
  end

  always_comb begin
    stall_ID_o = 1'b0;
    if (!rst) begin
      stall_ID_o = (issue_valid_ID_i && hazard) || (state_q != IDLE) ||
                   (drain_req_ID_i && (state_q == IDLE));
    end
  end

  assign fire   = issue_valid_ID_i && !stall_ID_o;
  assign set_en = fire && issue_we_ID_i && (issue_rd_ID_i != 5'd0);
  // Only a write retiring onto a busy entry counts as a clear.
  assign clr_en = clr_hit(we_WB_i, waddr_WB_i, waddr_WB_i) && busy_q[waddr_WB_i];

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[waddr_WB_i] = 1'b0;
    if (set_en) busy_d[issue_rd_ID_i] = 1'b1;
    outstanding_d = outstanding_q + CNT_W'(set_en) - CNT_W'(clr_en);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (drain_req_ID_i) state_d = DRAIN;
      DRAIN:   if (outstanding_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign drain_done_ID_o   = (state_q == DONE);
  assign busy_CPU_o        = busy_q;
  assign outstanding_CPU_o = outstanding_q;

  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef REGFILE_SB_STATS_EN
  logic [31:0] stall_cnt_q, raw_cnt_q;

  always_ff @(posedge dclk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      raw_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= sat_inc32(stall_cnt_q, stall_ID_o && issue_valid_ID_i);
      raw_cnt_q   <= sat_inc32(raw_cnt_q, stall_ID_o && issue_valid_ID_i && (raw1 || raw2));
    end
  end

  assign stall_cnt_CPU_o = stall_cnt_q;
  assign raw_cnt_CPU_o   = raw_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench for regfile_scoreboard (MAX_OUTSTANDING=4, CNT_W=5).
module tb_regfile_scoreboard;

  logic        dclk = 1'b0;
  logic        rst;
  logic        issue_valid_ID_i, issue_we_ID_i;
  logic [4:0]  issue_rd_ID_i;
  logic        re1_ID_i, re2_ID_i;
  logic [4:0]  raddr1_ID_i, raddr2_ID_i;
  logic        we_WB_i;
  logic [4:0]  waddr_WB_i;
  logic        drain_req_ID_i;
  logic        stall_ID_o, drain_done_ID_o;
  logic [31:0] busy_CPU_o;
  logic [4:0]  outstanding_CPU_o;
`ifdef REGFILE_SB_STATS_EN
  logic [31:0] stall_cnt_CPU_o, raw_cnt_CPU_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  regfile_scoreboard #(.MAX_OUTSTANDING(4), .CNT_W(5)) dut (
    .dclk              (dclk),
    .rst               (rst),
    .issue_valid_ID_i  (issue_valid_ID_i),
    .issue_we_ID_i     (issue_we_ID_i),
    .issue_rd_ID_i     (issue_rd_ID_i),
    .re1_ID_i          (re1_ID_i),
    .raddr1_ID_i       (raddr1_ID_i),
    .re2_ID_i          (re2_ID_i),
    .raddr2_ID_i       (raddr2_ID_i),
    .we_WB_i           (we_WB_i),
    .waddr_WB_i        (waddr_WB_i),
    .drain_req_ID_i    (drain_req_ID_i),
    .stall_ID_o        (stall_ID_o),
    .drain_done_ID_o   (drain_done_ID_o),
    .busy_CPU_o        (busy_CPU_o),
    .outstanding_CPU_o (outstanding_CPU_o)
`ifdef REGFILE_SB_STATS_EN
    ,
    .stall_cnt_CPU_o   (stall_cnt_CPU_o),
    .raw_cnt_CPU_o     (raw_cnt_CPU_o)
`endif
  );

  always #5 dclk = ~dclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid_ID_i = 1'b0; issue_we_ID_i = 1'b0; issue_rd_ID_i = 5'd0;
    re1_ID_i = 1'b0; raddr1_ID_i = 5'd0; re2_ID_i = 1'b0; raddr2_ID_i = 5'd0;
    we_WB_i = 1'b0; waddr_WB_i = 5'd0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    issue_valid_ID_i = 1'b1; issue_we_ID_i = 1'b1; issue_rd_ID_i = rd;
  endtask

  task automatic wb(input logic [4:0] wa);
    idle();
    we_WB_i = 1'b1; waddr_WB_i = wa;
  endtask

  initial begin
    idle();
    drain_req_ID_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    // Reset state; stall forced low while rst even with requests present.
    issue_wr(5'd1); drain_req_ID_i = 1'b1; #1;
    check_eq("rst_stall", stall_ID_o, 0);
    check_eq("rst_busy", busy_CPU_o, 0);
    check_eq("rst_outst", outstanding_CPU_o, 0);
    check_eq("rst_done", drain_done_ID_o, 0);
    tick();
    idle(); drain_req_ID_i = 1'b0; rst = 1'b0;
    check_eq("rst_busy2", busy_CPU_o, 0);
    tick();

    // 1: RAW on x5, relieved by same-cycle WB
    issue_wr(5'd5); #1;
    check_eq("t1_issue_stall", stall_ID_o, 0);
    tick();
    idle(); issue_valid_ID_i = 1'b1; re1_ID_i = 1'b1; raddr1_ID_i = 5'd5; #1;
    check_eq("t1_raw_stall", stall_ID_o, 1);
    check_eq("t1_busy", busy_CPU_o, 32'h20);
    check_eq("t1_outst", outstanding_CPU_o, 1);
    we_WB_i = 1'b1; waddr_WB_i = 5'd5; #1;
    check_eq("t1_wb_fwd", stall_ID_o, 0);
    tick();
    idle(); #1;
    check_eq("t1_busy_clr", busy_CPU_o, 0);
    check_eq("t1_outst_clr", outstanding_CPU_o, 0);

    // 2: writes to x0 and x3; x0 never busy
    issue_wr(5'd0); tick();
    issue_wr(5'd3); tick();
    idle(); #1;
    check_eq("t2_busy", busy_CPU_o, 32'h8);
    check_eq("t2_outst", outstanding_CPU_o, 1);
    issue_valid_ID_i = 1'b1; re1_ID_i = 1'b1; re2_ID_i = 1'b1; #1;
    check_eq("t2_x0_read", stall_ID_o, 0);
    re2_ID_i = 1'b0; raddr1_ID_i = 5'd3; re1_ID_i = 1'b0; re2_ID_i = 1'b1; raddr2_ID_i = 5'd3; #1;
    check_eq("t2_raw2", stall_ID_o, 1);
    wb(5'd3); tick();
    idle(); #1;
    check_eq("t2_outst_clr", outstanding_CPU_o, 0);

    // 3: cap of 4 outstanding writes
    for (int r = 1; r <= 4; r++) begin
      issue_wr(5'(r)); tick();
    end
    issue_wr(5'd6); #1;
    check_eq("t3_outst4", outstanding_CPU_o, 4);
    check_eq("t3_cap_stall", stall_ID_o, 1);
    idle(); issue_valid_ID_i = 1'b1; re1_ID_i = 1'b1; raddr1_ID_i = 5'd9; #1;
    check_eq("t3_rd_only", stall_ID_o, 0);
    issue_wr(5'd6); we_WB_i = 1'b1; waddr_WB_i = 5'd1; #1;
    check_eq("t3_cap_conserv", stall_ID_o, 1);
    tick();
    issue_wr(5'd6); #1;
    check_eq("t3_outst3", outstanding_CPU_o, 3);
    check_eq("t3_after_clr", stall_ID_o, 0);
    tick();
    idle(); #1;
    check_eq("t3_outst_back4", outstanding_CPU_o, 4);
    check_eq("t3_busy", busy_CPU_o, 32'h5C);

    // 4: set and clear of x7 in the same cycle
    wb(5'd2); tick(); wb(5'd3); tick(); wb(5'd4); tick(); wb(5'd6); tick();
    idle(); #1;
    check_eq("t4_empty", outstanding_CPU_o, 0);
    issue_wr(5'd7); tick();
    issue_wr(5'd7); we_WB_i = 1'b1; waddr_WB_i = 5'd7; #1;
    check_eq("t4_waw_relieved", stall_ID_o, 0);
    tick();
    idle(); #1;
    check_eq("t4_busy", busy_CPU_o, 32'h80);
    check_eq("t4_outst", outstanding_CPU_o, 1);
    issue_wr(5'd7); #1;
    check_eq("t4_waw_stall", stall_ID_o, 1);
    wb(5'd9); tick();
    idle(); #1;
    check_eq("t4_nonbusy_wb", outstanding_CPU_o, 1);

    // 5: drain with two pending writes, then with none
    issue_wr(5'd8); tick();
    idle(); drain_req_ID_i = 1'b1; #1;
    check_eq("t5_outst2", outstanding_CPU_o, 2);
    check_eq("t5_req_stall", stall_ID_o, 1);
    tick();
    check_eq("t5_drain_stall", stall_ID_o, 1);
    check_eq("t5_drain_nodone", drain_done_ID_o, 0);
    wb(5'd7); tick();
    wb(5'd8); tick();
    idle(); #1;
    check_eq("t5_outst0", outstanding_CPU_o, 0);
    check_eq("t5_still_drain", drain_done_ID_o, 0);
    check_eq("t5_still_stall", stall_ID_o, 1);
    tick();
    check_eq("t5_done", drain_done_ID_o, 1);
    check_eq("t5_done_stall", stall_ID_o, 1);
    drain_req_ID_i = 1'b0;
    tick();
    check_eq("t5_done_pulse", drain_done_ID_o, 0);
    check_eq("t5_idle_stall", stall_ID_o, 0);
    drain_req_ID_i = 1'b1; #1;
    check_eq("t5e_req_stall", stall_ID_o, 1);
    check_eq("t5e_nodone0", drain_done_ID_o, 0);
    tick();
    check_eq("t5e_nodone1", drain_done_ID_o, 0);
    tick();
    check_eq("t5e_done", drain_done_ID_o, 1);
    drain_req_ID_i = 1'b0;
    tick();
    check_eq("t5e_done_pulse", drain_done_ID_o, 0);

    // 6: reset mid-drain
    issue_wr(5'd10); tick();
    issue_wr(5'd11); tick();
    idle(); drain_req_ID_i = 1'b1; tick();
    check_eq("t6_outst2", outstanding_CPU_o, 2);
    check_eq("t6_drain_stall", stall_ID_o, 1);
    rst = 1'b1; #1;
    check_eq("t6_rst_stall", stall_ID_o, 0);
    tick();
    rst = 1'b0; drain_req_ID_i = 1'b0; #1;
    check_eq("t6_busy", busy_CPU_o, 0);
    check_eq("t6_outst", outstanding_CPU_o, 0);
    check_eq("t6_stall", stall_ID_o, 0);
    check_eq("t6_nodone0", drain_done_ID_o, 0);
    tick();
    check_eq("t6_nodone1", drain_done_ID_o, 0);
    tick();
    check_eq("t6_nodone2", drain_done_ID_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
